// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared defaults, FSM states and clog2 for the serializer path
package bit_serializer_pkg;

   localparam int   DEFAULT_WIDTH    = 8;
   localparam logic DEFAULT_IDLE_BIT = 1'b0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // Never returns less than 1 so a counter is always at least one bit wide.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-in serial-out stage with a one-word holding register
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int   WIDTH     = DEFAULT_WIDTH,
   parameter logic MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_in_data,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   output logic             o_bit_out,
   output logic             o_bit_valid,
   output logic             o_bit_last
);

   localparam int            CW   = clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state,     w_state_nxt;
   logic [WIDTH-1:0] r_shreg,     w_shreg_nxt;
   logic [CW-1:0]    r_cnt,       w_cnt_nxt;
   logic [WIDTH-1:0] r_hold,      w_hold_nxt;
   logic             r_hold_full, w_hold_full_nxt;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_shifted;

   assign o_in_ready = !r_hold_full && !i_reset;
   assign w_accept   = i_in_valid && o_in_ready;
   assign w_last     = (r_cnt == LAST);
   assign w_shifted  = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);

   // Outputs come only from registers, so in_data never reaches bit_out combinationally.
   assign o_bit_valid = (r_state == ST_SHIFT);
   assign o_bit_out   = (r_state == ST_SHIFT) ? (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0])
                                              : IDLE_BIT;
   assign o_bit_last  = (r_state == ST_SHIFT) && w_last;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shreg     <= w_shreg_nxt;
         r_cnt       <= w_cnt_nxt;
         r_hold      <= w_hold_nxt;
         r_hold_full <= w_hold_full_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_shreg_nxt     = r_shreg;
      w_cnt_nxt       = r_cnt;
      w_hold_nxt      = r_hold;
      w_hold_full_nxt = r_hold_full;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_shreg_nxt = i_in_data;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!w_last) begin
               w_shreg_nxt = w_shifted;
               w_cnt_nxt   = r_cnt + 1'b1;
               if (w_accept) begin
                  w_hold_nxt      = i_in_data;
                  w_hold_full_nxt = 1'b1;
               end
            end else if (r_hold_full) begin
               // in_ready is low while the hold is full, so no accept can race the drain.
               w_shreg_nxt     = r_hold;
               w_hold_full_nxt = 1'b0;
               w_cnt_nxt       = '0;
            end else if (w_accept) begin
               w_shreg_nxt = i_in_data;
               w_cnt_nxt   = '0;
            end else begin
               w_shreg_nxt = w_shifted;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - randomized and directed bench for bit_serializer against a bit-queue model
module tb_bit_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] data;
   logic         valid;

   logic m_ready, m_bit, m_bvalid, m_blast;
   logic l_ready, l_bit, l_bvalid, l_blast;

   int total = 0;
   int bad   = 0;
   logic accepted;

   // Pending output bits for each bit order, plus the shared end-of-word flags.
   logic qm[$];
   logic ql[$];
   logic qlast[$];

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_in_data   (data),
      .i_in_valid  (valid),
      .o_in_ready  (m_ready),
      .o_bit_out   (m_bit),
      .o_bit_valid (m_bvalid),
      .o_bit_last  (m_blast)
   );

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_in_data   (data),
      .i_in_valid  (valid),
      .o_in_ready  (l_ready),
      .o_bit_out   (l_bit),
      .o_bit_valid (l_bvalid),
      .o_bit_last  (l_blast)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      logic rdy;
      logic busy;
      rdy      = !reset && (qm.size() <= W);
      accepted = 1'b0;
      @(posedge clk);
      if (reset) begin
         qm.delete();
         ql.delete();
         qlast.delete();
      end else begin
         if (qm.size() > 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
            void'(qlast.pop_front());
         end
         if (valid && rdy) begin
            accepted = 1'b1;
            for (int i = 0; i < W; i++) begin
               qm.push_back(data[W-1-i]);
               ql.push_back(data[i]);
               qlast.push_back(i == W - 1);
            end
         end
      end
      #1;
      busy = (qm.size() > 0);
      chk("msb_ready",  m_ready,  !reset && (qm.size() <= W));
      chk("lsb_ready",  l_ready,  !reset && (qm.size() <= W));
      chk("msb_bvalid", m_bvalid, busy);
      chk("lsb_bvalid", l_bvalid, busy);
      chk("msb_bit",    m_bit,    busy ? qm[0] : 1'b0);
      chk("lsb_bit",    l_bit,    busy ? ql[0] : 1'b0);
      chk("msb_blast",  m_blast,  busy ? qlast[0] : 1'b0);
      chk("lsb_blast",  l_blast,  busy ? qlast[0] : 1'b0);
   endtask

   task automatic send(input logic [W-1:0] w);
      valid = 1'b1;
      data  = w;
      for (int k = 0; k < 4 * W; k++) begin
         step();
         if (accepted) return;
      end
      total++;
      bad++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted word=%h", w);
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      reset = 1'b1;
      valid = 1'b0;
      data  = '0;
      step();
      step();
      reset = 1'b0;
      idle(2);

      // Single word, then a word whose LSB-first stream is 0000_1011.
      send(8'b0000_1011);
      idle(W + 3);
      send(8'b1101_0000);
      idle(W + 3);

      // Back-to-back with valid held: 16 contiguous bits.
      send(8'hB0);
      send(8'hBB);
      idle(2 * W + 3);

      idle(20);

      // Reset mid-word with a word held, then a fresh word.
      send(8'hFF);
      send(8'h5A);
      valid = 1'b0;
      step();
      step();
      reset = 1'b1;
      valid = 1'b1;
      data  = 8'h3C;
      step();
      reset = 1'b0;
      valid = 1'b0;
      step();
      send(8'hC3);
      idle(W + 3);

      // Accept exactly on the last-bit cycle with the hold empty.
      send(8'h96);
      idle(W - 1);
      send(8'h69);
      idle(W + 3);

      for (int c = 0; c < 400; c++) begin
         valid = ($urandom_range(0, 3) != 0);
         data  = W'($urandom);
         reset = ($urandom_range(0, 63) == 0);
         step();
      end
      reset = 1'b0;
      idle(2 * W + 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
